// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// counter sizing and FSM state encodings.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/adder4.sv
// 4-bit carry-lookahead adder slice.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead carries within the slice
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/div_sub_stage.sv
// WIDTH-bit subtractor a - b built from rippled adder4 slices;
// no_borrow is high when a >= b.
module div_sub_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  localparam int unsigned NSL = WIDTH / 4;

  logic [NSL:0]     c;
  logic [WIDTH-1:0] b_n;

  assign b_n  = ~b;
  assign c[0] = 1'b1;

  for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
    adder4 u_add (
      .a    (a[4*gi +: 4]),
      .b    (b_n[4*gi +: 4]),
      .cin  (c[gi]),
      .sum  (diff[4*gi +: 4]),
      .cout (c[gi+1])
    );
  end

  assign no_borrow = c[NSL];

endmodule

// File: rtl/div_8_8_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder/div-by-zero with a one-cycle done pulse.
module div_8_8_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] r, r_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             dbz_nxt;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             ge;

  // Shift the next dividend bit into the partial remainder
  assign trial = {r, q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a         (trial[WIDTH-1:0]),
    .b         (dvs),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // A set top trial bit means trial exceeds any WIDTH-bit divisor
  assign ge = trial[WIDTH] | no_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    q_nxt     = q;
    dvs_nxt   = dvs;
    cnt_nxt   = cnt;
    quo_nxt   = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    case (state)
      S_RUN: begin
        r_nxt   = ge ? diff : trial[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], ge};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          quo_nxt   = q_nxt;
          rem_nxt   = r_nxt;
          dbz_nxt   = 1'b0;
          state_nxt = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        if (start) begin
          dvs_nxt = divisor;
          if (divisor == '0) begin
            quo_nxt   = '1;
            rem_nxt   = dividend;
            dbz_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            r_nxt     = '0;
            q_nxt     = dividend;
            cnt_nxt   = '0;
            state_nxt = S_RUN;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r           <= r_nxt;
      q           <= q_nxt;
      dvs         <= dvs_nxt;
      cnt         <= cnt_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
      busy        <= (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
    end
  end

endmodule
